// File: rtl/fpu_pkg.sv
// Shared FPU constants, flag positions and operand classification helper.
// Latency: n/a (package; classification is purely combinational).
// Backpressure: n/a.
package fpu_pkg;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [30:0] FP_INF  = 31'h7F80_0000;

    localparam int FLAG_NV = 1;
    localparam int FLAG_DZ = 0;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_snan;
    } fp_class_t;

    // Denormals are deliberately not flagged: they are ordinary divider operands.
    function automatic fp_class_t fp_classify(input logic [31:0] x);
        fp_class_t c;
        logic      exp_max;
        logic      exp_zero;
        logic      man_nz;
        exp_max   = &x[30:23];
        exp_zero  = ~|x[30:23];
        man_nz    = |x[22:0];
        c.is_zero = exp_zero && !man_nz;
        c.is_inf  = exp_max && !man_nz;
        c.is_nan  = exp_max && man_nz;
        c.is_snan = exp_max && man_nz && !x[22];
        return c;
    endfunction

endpackage

// File: rtl/fdiv_res_fifo.sv
// Result FIFO holding quotient, tag and flags, with occupancy exposed.
// Latency: a write is visible at the read port the cycle after the write edge.
// Backpressure: none on the write side; the upstream credit count keeps it from overflowing.
module fdiv_res_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [1:0]        wr_flags,
    input  logic              rd_en,
    output logic              rd_vld,
    output logic [DATA_W-1:0] rd_data,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [1:0]        rd_flags,
    output logic [CNT_W-1:0]  count
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic [1:0]        flags;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign do_pop   = rd_en && rd_vld;
    assign rd_vld   = (count != '0);
    assign rd_data  = mem[rd_ptr].data;
    assign rd_tag   = mem[rd_ptr].tag;
    assign rd_flags = mem[rd_ptr].flags;

    // Storage; cleared on reset so the read port shows zeros until the first write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= '{data: wr_data, tag: wr_tag, flags: wr_flags};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks push minus pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Writing into a full FIFO means the credit accounting upstream is broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(wr_en && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/fdiv_seq.sv
// Issue/retire sequencer for the pipelined divider; resolves IEEE special operands locally.
// Latency: accept at edge N is written to the result FIFO at edge N+DIV_LAT (out_valid after it).
// Backpressure: in_ready is a credit check (inflight + queued < FIFO_DEPTH), independent of out_ready.
module fdiv_seq
    import fpu_pkg::*;
#(
    parameter int DIV_LAT    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      div_rs1,
    output logic [31:0]      div_rs2,
    input  logic [31:0]      div_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       out_flags
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    typedef struct packed {
        logic             v;
        logic             special;
        logic [TAG_W-1:0] tag;
        logic [1:0]       flags;
        logic [31:0]      res;
    } stage_t;

    stage_t           pipe [DIV_LAT];
    stage_t           stage_in;
    stage_t           tail;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] fifo_count;
    logic             accept;
    logic             special;
    logic [31:0]      spec_res;
    logic [1:0]       spec_flags;
    logic [31:0]      wr_data;
    fp_class_t        c1;
    fp_class_t        c2;
    logic             s;

    assign in_ready = ({1'b0, inflight} + {1'b0, fifo_count}) < SUM_W'(FIFO_DEPTH);
    assign accept   = in_valid && in_ready;
    assign tail     = pipe[DIV_LAT-1];
    assign wr_data  = tail.special ? tail.res : div_out;

    // Classify operands; the order matters: NaN first, then invalid, then inf/x before x/0.
    always_comb begin
        c1         = fp_classify(in_rs1);
        c2         = fp_classify(in_rs2);
        s          = in_rs1[31] ^ in_rs2[31];
        special    = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if (c1.is_nan || c2.is_nan) begin
            spec_res            = FP_QNAN;
            spec_flags[FLAG_NV] = c1.is_snan || c2.is_snan;
        end else if ((c1.is_zero && c2.is_zero) || (c1.is_inf && c2.is_inf)) begin
            spec_res            = FP_QNAN;
            spec_flags[FLAG_NV] = 1'b1;
        end else if (c1.is_inf) begin
            spec_res = {s, FP_INF};
        end else if (c2.is_zero) begin
            spec_res            = {s, FP_INF};
            spec_flags[FLAG_DZ] = 1'b1;
        end else if (c2.is_inf || c1.is_zero) begin
            spec_res = {s, 31'd0};
        end else begin
            special = 1'b0;
        end
    end

    // Divider only sees real work; idle cycles and special requests present zeros.
    always_comb begin
        div_rs1 = '0;
        div_rs2 = '0;
        if (accept && !special) begin
            div_rs1 = in_rs1;
            div_rs2 = in_rs2;
        end
    end

    // Build the tracking entry for this cycle's accept (an empty bubble otherwise).
    always_comb begin
        stage_in = '0;
        if (accept) begin
            stage_in.v       = 1'b1;
            stage_in.special = special;
            stage_in.tag     = in_tag;
            stage_in.flags   = spec_flags;
            stage_in.res     = spec_res;
        end
    end

    // Tracking pipe runs in lockstep with the divider so specials keep request order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DIV_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= stage_in;
            for (int i = 1; i < DIV_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // In-flight credit count: up on accept, down when the tail retires into the FIFO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inflight <= '0;
        end else begin
            case ({accept, tail.v})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    fdiv_res_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (32),
        .TAG_W  (TAG_W)
    ) u_res_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (tail.v),
        .wr_data  (wr_data),
        .wr_tag   (tail.tag),
        .wr_flags (tail.flags),
        .rd_en    (out_ready),
        .rd_vld   (out_valid),
        .rd_data  (out_data),
        .rd_tag   (out_tag),
        .rd_flags (out_flags),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_fdiv_seq.sv
// Scoreboard bench for fdiv_seq with a fixed-latency divider model beside it.
// Latency: model divider output appears DIV_LAT cycles after operands are sampled.
// Backpressure: bench toggles out_ready to exercise the credit limit.
module tb_fdiv_seq;

    localparam int DIV_LAT    = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int TAG_W      = 5;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_rs1 = '0;
    logic [31:0]      in_rs2 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [31:0]      div_rs1;
    logic [31:0]      div_rs2;
    logic [31:0]      div_out;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic [1:0]       out_flags;

    fdiv_seq #(
        .DIV_LAT    (DIV_LAT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TAG_W      (TAG_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_tag    (in_tag),
        .div_rs1   (div_rs1),
        .div_rs2   (div_rs2),
        .div_out   (div_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    // Hand-computed quotients for the normal operand pairs used below.
    function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40C0_0000, 32'h4000_0000}: return 32'h4040_0000; // 6 / 2 = 3
            {32'h3F80_0000, 32'h4000_0000}: return 32'h3F00_0000; // 1 / 2 = 0.5
            {32'h4100_0000, 32'h4080_0000}: return 32'h4000_0000; // 8 / 4 = 2
            {32'hC110_0000, 32'h4040_0000}: return 32'hC040_0000; // -9 / 3 = -3
            {32'h0000_0001, 32'h3F80_0000}: return 32'h0000_0001; // denorm / 1
            default:                        return 32'hDEAD_BEEF;
        endcase
    endfunction

    logic [31:0] mdl_pipe [DIV_LAT];
    always @(posedge clk) begin
        mdl_pipe[0] <= model_div(div_rs1, div_rs2);
        for (int i = 1; i < DIV_LAT; i++) mdl_pipe[i] <= mdl_pipe[i-1];
    end
    assign div_out = mdl_pipe[DIV_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic [1:0]       flags;
        int               acc_cyc;
        bit               lat_chk;
        bit               consec_chk;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_push = 0;
    int   n_pop = 0;
    int   last_pop = -100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t,
                        input logic [31:0] ed, input logic [1:0] ef,
                        input bit lat, input bit consec, input bit push);
        bit   rdy;
        bit   done;
        exp_t e;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_rs1   = a;
            in_rs2   = b;
            in_tag   = t;
            rdy      = in_ready;
            @(posedge clk);
            if (rdy) begin
                done = 1'b1;
                if (push) begin
                    e.data = ed; e.tag = t; e.flags = ef;
                    e.acc_cyc = cyc; e.lat_chk = lat; e.consec_chk = consec;
                    sb.push_back(e);
                    n_push++;
                end
            end
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout tag %0d: in_ready never seen in 50 cycles, required 1", t);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_rs1   = '0;
        in_rs2   = '0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("drain_queue_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        bit rdy;
        int acc;
        exp_t e;

        // Monitor: pops the scoreboard whenever the DUT hands over a result.
        fork
            forever begin
                @(negedge clk);
                #1;
                if (resetn && out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result_tag", {27'd0, out_tag}, 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        n_pop++;
                        check($sformatf("data_tag%0d", e.tag), out_data, e.data);
                        check($sformatf("tag_tag%0d", e.tag), {27'd0, out_tag}, {27'd0, e.tag});
                        check($sformatf("flags_tag%0d", e.tag), {30'd0, out_flags}, {30'd0, e.flags});
                        if (e.lat_chk)
                            check($sformatf("latency_tag%0d", e.tag), cyc - e.acc_cyc, DIV_LAT + 1);
                        if (e.consec_chk)
                            check($sformatf("consecutive_tag%0d", e.tag), cyc - last_pop, 1);
                    end
                    last_pop = cyc;
                end
            end
        join_none

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 1);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_out_valid_post", {31'd0, out_valid}, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", {27'd0, out_tag}, 0);
        check("rst_out_flags", {30'd0, out_flags}, 0);
        check("rst_in_ready_post", {31'd0, in_ready}, 1);

        // Single normal divide with exact latency.
        send(32'h40C0_0000, 32'h4000_0000, 5'd3, 32'h4040_0000, 2'b00, 1, 0, 1);
        idle();
        drain();

        // Special operands.
        send(32'h3F80_0000, 32'h0000_0000, 5'd4, 32'h7F80_0000, 2'b01, 0, 0, 1); // 1/0
        send(32'h8000_0000, 32'h0000_0000, 5'd5, 32'h7FC0_0000, 2'b10, 0, 0, 1); // -0/0
        send(32'hBF80_0000, 32'h7F80_0000, 5'd6, 32'h8000_0000, 2'b00, 0, 0, 1); // -1/inf
        send(32'h7F80_0001, 32'h3F80_0000, 5'd7, 32'h7FC0_0000, 2'b10, 0, 0, 1); // sNaN/1
        send(32'h7FC0_0000, 32'h3F80_0000, 5'd8, 32'h7FC0_0000, 2'b00, 0, 0, 1); // qNaN/1
        idle();
        drain();
        send(32'h7F80_0000, 32'hFF80_0000, 5'd9, 32'h7FC0_0000, 2'b10, 0, 0, 1);  // inf/-inf
        send(32'hFF80_0000, 32'h4000_0000, 5'd10, 32'hFF80_0000, 2'b00, 0, 0, 1); // -inf/2
        send(32'h7F80_0000, 32'h8000_0000, 5'd11, 32'hFF80_0000, 2'b00, 0, 0, 1); // inf/-0
        send(32'h0000_0001, 32'h3F80_0000, 5'd12, 32'h0000_0001, 2'b00, 0, 0, 1); // denorm
        idle();
        drain();

        // Back-to-back mix retires in order on consecutive cycles.
        send(32'h3F80_0000, 32'h4000_0000, 5'd1, 32'h3F00_0000, 2'b00, 0, 0, 1);
        send(32'h0000_0000, 32'h4000_0000, 5'd2, 32'h0000_0000, 2'b00, 0, 1, 1);
        send(32'h4100_0000, 32'h4080_0000, 5'd3, 32'h4000_0000, 2'b00, 0, 1, 1);
        idle();
        drain();

        // Stall the consumer under a continuous stream: only FIFO_DEPTH credits exist.
        @(negedge clk);
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_tag   = TAG_W'(16 + acc);
            if (acc[0]) begin
                in_rs1 = 32'hC110_0000; in_rs2 = 32'h4040_0000;
            end else begin
                in_rs1 = 32'h3F80_0000; in_rs2 = 32'h0000_0000;
            end
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                e.data  = acc[0] ? 32'hC040_0000 : 32'h7F80_0000;
                e.flags = acc[0] ? 2'b00 : 2'b01;
                e.tag = TAG_W'(16 + acc); e.acc_cyc = cyc; e.lat_chk = 0; e.consec_chk = 0;
                sb.push_back(e);
                n_push++;
                acc++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("stall_accept_count", acc, FIFO_DEPTH);
        check("stall_in_ready", {31'd0, in_ready}, 0);
        out_ready = 1'b1;
        drain();
        check("stall_in_ready_after", {31'd0, in_ready}, 1);

        // Reset with requests in flight: everything is discarded.
        send(32'h40C0_0000, 32'h4000_0000, 5'd20, 32'h0, 2'b00, 0, 0, 0);
        send(32'h3F80_0000, 32'h0000_0000, 5'd21, 32'h0, 2'b00, 0, 0, 0);
        send(32'h4100_0000, 32'h4080_0000, 5'd22, 32'h0, 2'b00, 0, 0, 0);
        idle();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < DIV_LAT + 2; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("post_reset_out_valid_%0d", i), {31'd0, out_valid}, 0);
        end
        check("post_reset_in_ready", {31'd0, in_ready}, 1);

        // Recovery after reset.
        send(32'hC110_0000, 32'h4040_0000, 5'd30, 32'hC040_0000, 2'b00, 1, 0, 1);
        idle();
        drain();

        check("pop_count", n_pop, n_push);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
